// File: rtl/memory_access_unit_if.sv
// Data-memory request/response channel between the memory stage and data memory.
// The memory stage is the master: it drives requests and consumes responses.
interface memory_access_unit_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
);
    logic                    dmem_req_valid;
    logic                    dmem_req_ready;
    logic                    dmem_req_write;
    logic [ADDRESS_BITS-1:0] dmem_req_addr;
    logic [DATA_WIDTH-1:0]   dmem_req_wdata;
    logic                    dmem_resp_valid;
    logic [DATA_WIDTH-1:0]   dmem_resp_rdata;

    modport master (
        output dmem_req_valid, dmem_req_write, dmem_req_addr, dmem_req_wdata,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_req_write, dmem_req_addr, dmem_req_wdata,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );
endinterface

// File: rtl/memory_access_unit.sv
// Memory stage: issues full-word loads/stores to data memory, stalls upstream while an
// access is outstanding, and registers the memory-to-writeback values.
module memory_access_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDRESS_BITS = 20,
    parameter logic [DATA_WIDTH-1:0] NOP          = 32'h00000013
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] ALU_result_memory,
    input  logic [DATA_WIDTH-1:0] store_data_memory,
    input  logic [4:0]            rd_memory,
    input  logic                  memRead_memory,
    input  logic                  memWrite_memory,
    input  logic                  regWrite_memory,
    input  logic [DATA_WIDTH-1:0] instruction_memory,
    memory_access_unit_if.master  dmem,
    output logic                  stall_memory,
    output logic [DATA_WIDTH-1:0] write_data_writeback,
    output logic [4:0]            rd_writeback,
    output logic                  regWrite_writeback,
    output logic [DATA_WIDTH-1:0] instruction_writeback
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t r_state, w_next;

    logic w_is_load, w_is_store, w_mem_op, w_stall;

    // Opcode qualification keeps the post-reset NOP (which carries memRead=1) from issuing.
    assign w_is_load  = memRead_memory  && (instruction_memory[6:0] == 7'b0000011);
    assign w_is_store = memWrite_memory && (instruction_memory[6:0] == 7'b0100011);
    assign w_mem_op   = w_is_load || w_is_store;

    logic                    r_req_valid, r_req_write;
    logic [ADDRESS_BITS-1:0] r_req_addr;
    logic [DATA_WIDTH-1:0]   r_req_wdata, r_alu, r_rdata, r_instr;
    logic [4:0]              r_rd;
    logic                    r_rw;

    logic [DATA_WIDTH-1:0] w_wb_data, w_wb_instr;
    logic [4:0]            w_wb_rd;
    logic                  w_wb_rw;

    logic [DATA_WIDTH-1:0] r_wb_data, r_wb_instr;
    logic [4:0]            r_wb_rd;
    logic                  r_wb_rw;

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = w_mem_op;
                if (w_mem_op) w_next = S_REQ;
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (dmem.dmem_req_ready) w_next = r_req_write ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (dmem.dmem_resp_valid) w_next = S_DONE;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (reset) w_stall = 1'b0;
    end

    assign stall_memory = w_stall;

    // Request fields are captured once on issue and held untouched until the handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_req_valid <= 1'b0;
            r_req_write <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_alu       <= '0;
            r_rdata     <= '0;
            r_rd        <= '0;
            r_rw        <= 1'b0;
            r_instr     <= NOP;
        end else begin
            r_req_valid <= (w_next == S_REQ);
            if (r_state == S_IDLE && w_mem_op) begin
                r_req_write <= w_is_store;
                r_req_addr  <= ALU_result_memory[ADDRESS_BITS+1:2];
                r_req_wdata <= store_data_memory;
                r_alu       <= ALU_result_memory;
                r_rd        <= rd_memory;
                r_rw        <= regWrite_memory;
                r_instr     <= instruction_memory;
            end
            if (r_state == S_WAIT && dmem.dmem_resp_valid) r_rdata <= dmem.dmem_resp_rdata;
        end
    end

    always_comb begin
        w_wb_data  = '0;
        w_wb_rd    = '0;
        w_wb_rw    = 1'b0;
        w_wb_instr = NOP;
        case (r_state)
            S_IDLE: if (!w_mem_op) begin
                w_wb_data  = ALU_result_memory;
                w_wb_rd    = rd_memory;
                w_wb_rw    = regWrite_memory;
                w_wb_instr = instruction_memory;
            end
            S_DONE: begin
                w_wb_data  = r_req_write ? r_alu : r_rdata;
                w_wb_rd    = r_rd;
                w_wb_rw    = r_rw;
                w_wb_instr = r_instr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wb_data  <= '0;
            r_wb_rd    <= '0;
            r_wb_rw    <= 1'b0;
            r_wb_instr <= NOP;
        end else begin
            r_wb_data  <= w_wb_data;
            r_wb_rd    <= w_wb_rd;
            r_wb_rw    <= w_wb_rw;
            r_wb_instr <= w_wb_instr;
        end
    end

    assign dmem.dmem_req_valid  = r_req_valid;
    assign dmem.dmem_req_write  = r_req_write;
    assign dmem.dmem_req_addr   = r_req_addr;
    assign dmem.dmem_req_wdata  = r_req_wdata;
    assign write_data_writeback  = r_wb_data;
    assign rd_writeback          = r_wb_rd;
    assign regWrite_writeback    = r_wb_rw;
    assign instruction_writeback = r_wb_instr;
endmodule
